// File: rtl/dp_share_arbiter_if.sv
// Requester-side handshake bundle for dp_share_arbiter.
// The arbiter uses the slave modport; requester logic uses the master modport.
interface dp_share_arbiter_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [9:0]  req_A0;
   logic [8:0]  req_C0;
   logic [9:0]  req_A1;
   logic [8:0]  req_C1;
   logic [1:0]  rsp_valid;
   logic [10:0] rsp_data;

   modport master (
      output req_valid, req_A0, req_C0, req_A1, req_C1,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_A0, req_C0, req_A1, req_C1,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/dp_share_arbiter.sv
// Round-robin owner of a shared fixed-latency datapath; one operation in flight.
// Optional DP_ARB_STATS_EN adds saturating per-requester accept counters.
module dp_share_arbiter #(
   parameter int unsigned LAT    = 2,
   parameter logic [8:0]  PARK_C = 9'd0
) (
   input  logic                clk,
   input  logic                rst,
   dp_share_arbiter_if.slave   bus,
   output logic [9:0]          dp_A,
   output logic [8:0]          dp_C,
   input  logic [10:0]         dp_out,
   output logic                busy
`ifdef DP_ARB_STATS_EN
   ,
   output logic [15:0]         gnt_cnt0,
   output logic [15:0]         gnt_cnt1
`endif
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_gnt_q, last_gnt_d;
   logic [9:0]  dp_a_q, dp_a_d;
   logic [8:0]  dp_c_q, dp_c_d;
   logic [10:0] rsp_data_q, rsp_data_d;
   logic        gnt;
   logic        accept;

   // Contested cycles alternate; an uncontested requester simply wins.
   assign gnt    = (bus.req_valid == 2'b11) ? ~last_gnt_q : bus.req_valid[1];
   assign accept = (state_q == StIdle) && (bus.req_valid != 2'b00);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      owner_d       = owner_q;
      last_gnt_d    = last_gnt_q;
      dp_a_d        = dp_a_q;
      dp_c_d        = dp_c_q;
      rsp_data_d    = rsp_data_q;
      bus.req_ready = 2'b00;
      unique case (state_q)
         StIdle: begin
            bus.req_ready[gnt] = bus.req_valid[gnt];
            if (accept) begin
               dp_a_d     = gnt ? bus.req_A1 : bus.req_A0;
               dp_c_d     = gnt ? bus.req_C1 : bus.req_C0;
               cnt_d      = 4'(LAT);
               owner_d    = gnt;
               last_gnt_d = gnt;
               state_d    = StBusy;
            end
         end
         StBusy: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               rsp_data_d = dp_out;
               // Park C so the datapath idles on its default branch during RESP.
               dp_c_d     = PARK_C;
               state_d    = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
         dp_a_q     <= 10'd0;
         dp_c_q     <= PARK_C;
         rsp_data_q <= 11'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
         dp_a_q     <= dp_a_d;
         dp_c_q     <= dp_c_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      bus.rsp_valid = 2'b00;
      if (state_q == StResp) begin
         bus.rsp_valid[owner_q] = 1'b1;
      end
   end

   assign bus.rsp_data = rsp_data_q;
   assign dp_A         = dp_a_q;
   assign dp_C         = dp_c_q;
   assign busy         = (state_q != StIdle);

`ifdef DP_ARB_STATS_EN
   logic [15:0] gnt_cnt0_q, gnt_cnt1_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_cnt0_q <= 16'd0;
         gnt_cnt1_q <= 16'd0;
      end else if (accept) begin
         if (!gnt && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
         if (gnt && gnt_cnt1_q != 16'hFFFF)  gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
      end
   end

   assign gnt_cnt0 = gnt_cnt0_q;
   assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Scoreboard bench for dp_share_arbiter; datapath modelled as out = A + C.
module tb_dp_share_arbiter;
   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  dp_A;
   logic [8:0]  dp_C;
   logic [10:0] dp_out;
   logic        busy;
`ifdef DP_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

   dp_share_arbiter_if bus();

   dp_share_arbiter #(.LAT(LAT), .PARK_C(9'd0)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .dp_A   (dp_A),
      .dp_C   (dp_C),
      .dp_out (dp_out),
      .busy   (busy)
`ifdef DP_ARB_STATS_EN
      ,
      .gnt_cnt0 (gnt_cnt0),
      .gnt_cnt1 (gnt_cnt1)
`endif
   );

   always #5 clk = ~clk;
   assign dp_out = 11'(dp_A) + 11'(dp_C);

   typedef struct packed {
      logic [1:0]  vld;
      logic [10:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total  = 0;
   int   passed = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: every response pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && bus.rsp_valid !== 2'b00) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_valid", 32'(bus.rsp_valid), 32'(e.vld));
            check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            check("dp_c_park_in_resp", 32'(dp_C), 32'd0);
         end
      end
   end

   // Called just after a negedge with inputs set; returns at the negedge after the accept edge.
   task automatic accept(input logic [1:0] exp_ready, input string name, input bit push,
                         output int acc_cyc);
      int   n = 0;
      exp_t e;
      #1;
      while (bus.req_ready === 2'b00 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_ready"}, 32'(bus.req_ready), 32'(exp_ready));
      acc_cyc = cyc;
      if (push) begin
         e.vld  = exp_ready;
         e.data = exp_ready[1] ? 11'(bus.req_A1) + 11'(bus.req_C1)
                               : 11'(bus.req_A0) + 11'(bus.req_C0);
         exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   int c, prev;
   logic [9:0] a1_tab [3] = '{10'd100, 10'd1023, 10'd0};
   logic [8:0] c1_tab [3] = '{9'd60, 9'd511, 9'd0};

   initial begin
      rst = 1'b1;
      bus.req_valid = 2'b00;
      bus.req_A0 = 10'd45;  bus.req_C0 = 9'd75;
      bus.req_A1 = 10'd100; bus.req_C1 = 9'd60;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dp_a", 32'(dp_A), 32'd0);
      check("rst_dp_c", 32'(dp_C), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single req0 with latency tracking
      bus.req_valid = 2'b01;
      accept(2'b01, "t2", 1'b1, c);
      bus.req_valid = 2'b00;
      check("t2_dp_a", 32'(dp_A), 32'd45);
      check("t2_dp_c", 32'(dp_C), 32'd75);
      check("t2_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t2_rsp_early", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check("t2_rsp_at_lat", 32'(bus.rsp_valid), 32'd1);
      @(negedge clk);
      check("t2_idle_busy", 32'(busy), 32'd0);
      check("t2_rsp_done", 32'(bus.rsp_valid), 32'd0);
      check("t2_rsp_hold", 32'(bus.rsp_data), 32'd120);

      // Both valid from reset: alternate starting with req0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 2'b11;
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         accept((k % 2 == 0) ? 2'b01 : 2'b10, "t3", 1'b1, c);
         if (k > 0) check("t3_spacing", 32'(c - prev), 32'(LAT + 2));
         prev = c;
      end
      bus.req_valid = 2'b00;
      drain("t3");
`ifdef DP_ARB_STATS_EN
      check("t6_gnt_cnt0", 32'(gnt_cnt0), 32'd3);
      check("t6_gnt_cnt1", 32'(gnt_cnt1), 32'd2);
`endif

      // Reset during BUSY aborts the operation
      bus.req_valid = 2'b01;
      accept(2'b01, "t4_pre", 1'b0, c);
      rst = 1'b1;
      #1;
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_dp_a", 32'(dp_A), 32'd0);
      check("t4_dp_c", 32'(dp_C), 32'd0);
      check("t4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = 2'b11;
      accept(2'b01, "t4_first", 1'b1, c);
      bus.req_valid = 2'b00;
      drain("t4");

      // req1 back to back with changing operands
      bus.req_valid = 2'b10;
      for (int k = 0; k < 3; k++) begin
         bus.req_A1 = a1_tab[k];
         bus.req_C1 = c1_tab[k];
         accept(2'b10, "t5", 1'b1, c);
         if (k > 0) check("t5_spacing", 32'(c - prev), 32'(LAT + 2));
         prev = c;
      end
      bus.req_valid = 2'b00;
      drain("t5");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
